// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light sequencer.
// TLC_NIGHT_FLASH_EN adds the NIGHT state code.
package tlc_pkg;

  localparam int TIMER_W = 16;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_WALK        = 3'd3,
    ST_SIDE_GREEN  = 3'd4,
    ST_SIDE_YELLOW = 3'd5,
    ST_ALL_RED_B   = 3'd6
`ifdef TLC_NIGHT_FLASH_EN
    ,
    ST_NIGHT       = 3'd7
`endif
  } state_t;

  // True on the tick that completes a dwell of 'dwell' ticks.
  function automatic logic dwell_done(input logic tick,
                                      input logic [TIMER_W-1:0] timer,
                                      input int dwell);
    return tick && (timer == TIMER_W'(dwell - 1));
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks (TICK_DIV >= 2).
module tlc_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Wrap to zero on the tick, otherwise count up.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer: main road, side road, one pedestrian crossing.
// Optional night flashing mode is built in when TLC_NIGHT_FLASH_EN is defined.
//
// state          | meaning
// MAIN_GREEN     | main G, side R; waits MIN_GREEN then serves a request
// MAIN_YELLOW    | main Y, side R
// ALL_RED_A      | clearance before pedestrian or side phase
// WALK           | both R, walk lamp on
// SIDE_GREEN     | main R, side G
// SIDE_YELLOW    | main R, side Y
// ALL_RED_B      | clearance before returning to main green
// NIGHT          | main Y / side R flashing (TLC_NIGHT_FLASH_EN only)
module traffic_light_ctrl import tlc_pkg::*; #(
  parameter int TICK_DIV    = 100000,
  parameter int MIN_GREEN   = 5000,
  parameter int YELLOW_TIME = 3000,
  parameter int ALLRED_TIME = 1000,
  parameter int SIDE_TIME   = 8000,
  parameter int WALK_TIME   = 10000
`ifdef TLC_NIGHT_FLASH_EN
  ,
  parameter int FLASH_TICKS = 500
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_btn_n,
  input  logic       car_sensor,
`ifdef TLC_NIGHT_FLASH_EN
  input  logic       night_mode,
`endif
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic       ped_ack
);

  logic tick;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 ped_pending_q, ped_pending_d;
  logic                 btn_prev_q;
  logic [2:0]           main_q, main_d, side_q, side_d;
  logic                 walk_q, walk_d, ped_ack_q, ped_ack_d;
  logic                 ped_fall;
`ifdef TLC_NIGHT_FLASH_EN
  logic                 flash_q, flash_d;
`endif

  // Button is already debounced; a 1->0 step is a new request.
  assign ped_fall = btn_prev_q & ~ped_btn_n;

  // Next-state, dwell timer, request latch and Moore lamp decode.
  always_comb begin
    state_d = state_q;
    timer_d = tick ? timer_q + 1'b1 : timer_q;
`ifdef TLC_NIGHT_FLASH_EN
    flash_d = flash_q;
`endif
    case (state_q)
      ST_MAIN_GREEN: begin
        // Saturate so a late request is served on the very next tick.
        if (tick && (timer_q == TIMER_W'(MIN_GREEN - 1))) timer_d = timer_q;
`ifdef TLC_NIGHT_FLASH_EN
        if (tick && night_mode) state_d = ST_NIGHT;
        else
`endif
        if (dwell_done(tick, timer_q, MIN_GREEN) && (ped_pending_q || car_sensor))
          state_d = ST_MAIN_YELLOW;
      end
      ST_MAIN_YELLOW: if (dwell_done(tick, timer_q, YELLOW_TIME)) state_d = ST_ALL_RED_A;
      ST_ALL_RED_A: begin
        // Pedestrian wins; side green is served even if the car has left.
        if (dwell_done(tick, timer_q, ALLRED_TIME))
          state_d = ped_pending_q ? ST_WALK : ST_SIDE_GREEN;
      end
      ST_WALK:        if (dwell_done(tick, timer_q, WALK_TIME))   state_d = ST_ALL_RED_B;
      ST_SIDE_GREEN:  if (dwell_done(tick, timer_q, SIDE_TIME))   state_d = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (dwell_done(tick, timer_q, YELLOW_TIME)) state_d = ST_ALL_RED_B;
      ST_ALL_RED_B:   if (dwell_done(tick, timer_q, ALLRED_TIME)) state_d = ST_MAIN_GREEN;
`ifdef TLC_NIGHT_FLASH_EN
      ST_NIGHT: begin
        if (tick && !night_mode) begin
          state_d = ST_ALL_RED_B;
        end else if (dwell_done(tick, timer_q, FLASH_TICKS)) begin
          timer_d = '0;
          flash_d = ~flash_q;
        end
      end
`endif
      default: state_d = ST_ALL_RED_B;
    endcase

    if (state_d != state_q) timer_d = '0;
`ifdef TLC_NIGHT_FLASH_EN
    if ((state_d == ST_NIGHT) && (state_q != ST_NIGHT)) flash_d = 1'b1;
`endif

    ped_ack_d     = (state_d == ST_WALK) && (state_q != ST_WALK);
    ped_pending_d = ped_pending_q;
    if (ped_ack_d) ped_pending_d = 1'b0;
    // A press landing on the WALK entry edge is kept for the next cycle.
    if (ped_fall)  ped_pending_d = 1'b1;
`ifdef TLC_NIGHT_FLASH_EN
    if ((state_q == ST_NIGHT) || (state_d == ST_NIGHT)) ped_pending_d = 1'b0;
`endif

    main_d = LAMP_RED;
    side_d = LAMP_RED;
    walk_d = 1'b0;
    case (state_d)
      ST_MAIN_GREEN:  main_d = LAMP_GRN;
      ST_MAIN_YELLOW: main_d = LAMP_YEL;
      ST_WALK:        walk_d = 1'b1;
      ST_SIDE_GREEN:  side_d = LAMP_GRN;
      ST_SIDE_YELLOW: side_d = LAMP_YEL;
`ifdef TLC_NIGHT_FLASH_EN
      ST_NIGHT: begin
        main_d = flash_d ? LAMP_YEL : LAMP_OFF;
        side_d = flash_d ? LAMP_RED : LAMP_OFF;
      end
`endif
      default: ;
    endcase
  end

  // All sequencer state and registered lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_MAIN_GREEN;
      timer_q       <= '0;
      ped_pending_q <= 1'b0;
      btn_prev_q    <= 1'b1;
      main_q        <= LAMP_GRN;
      side_q        <= LAMP_RED;
      walk_q        <= 1'b0;
      ped_ack_q     <= 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
      flash_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      ped_pending_q <= ped_pending_d;
      btn_prev_q    <= ped_btn_n;
      main_q        <= main_d;
      side_q        <= side_d;
      walk_q        <= walk_d;
      ped_ack_q     <= ped_ack_d;
`ifdef TLC_NIGHT_FLASH_EN
      flash_q       <= flash_d;
`endif
    end
  end

  assign main_lights = main_q;
  assign side_lights = side_q;
  assign walk        = walk_q;
  assign ped_ack     = ped_ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl. Each scenario queues the expected
// lamp phases and their dwell in clocks; the monitor pops one entry per
// observed lamp change. Night scenario is built when TLC_NIGHT_FLASH_EN is set.
module tb_traffic_light_ctrl;

  localparam int TICK_DIV    = 4;
  localparam int MIN_GREEN   = 3;
  localparam int YELLOW_TIME = 2;
  localparam int ALLRED_TIME = 1;
  localparam int SIDE_TIME   = 4;
  localparam int WALK_TIME   = 5;
`ifdef TLC_NIGHT_FLASH_EN
  localparam int FLASH_TICKS = 2;
`endif

  // {main, side, walk}
  localparam logic [6:0] L_MG = {3'b001, 3'b100, 1'b0};
  localparam logic [6:0] L_MY = {3'b010, 3'b100, 1'b0};
  localparam logic [6:0] L_AR = {3'b100, 3'b100, 1'b0};
  localparam logic [6:0] L_WK = {3'b100, 3'b100, 1'b1};
  localparam logic [6:0] L_SG = {3'b100, 3'b001, 1'b0};
  localparam logic [6:0] L_SY = {3'b100, 3'b010, 1'b0};
`ifdef TLC_NIGHT_FLASH_EN
  localparam logic [6:0] L_NL = {3'b010, 3'b100, 1'b0};
  localparam logic [6:0] L_NO = {3'b000, 3'b000, 1'b0};
`endif

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       ped_btn_n  = 1'b1;
  logic       car_sensor = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
  logic       night_mode = 1'b0;
`endif
  logic [2:0] main_lights, side_lights;
  logic       walk, ped_ack;

  traffic_light_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .MIN_GREEN   (MIN_GREEN),
    .YELLOW_TIME (YELLOW_TIME),
    .ALLRED_TIME (ALLRED_TIME),
    .SIDE_TIME   (SIDE_TIME),
    .WALK_TIME   (WALK_TIME)
`ifdef TLC_NIGHT_FLASH_EN
    ,
    .FLASH_TICKS (FLASH_TICKS)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ped_btn_n   (ped_btn_n),
    .car_sensor  (car_sensor),
`ifdef TLC_NIGHT_FLASH_EN
    .night_mode  (night_mode),
`endif
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk        (walk),
    .ped_ack     (ped_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] lamps;
    int         dwell;   // 0: length not checked (phase relative to reset release)
  } exp_t;

  exp_t       exp_q[$];
  int         applied = 0;
  int         errors  = 0;
  int         ack_cnt = 0;
  logic [6:0] prev_l, cur_l;
  int         seg_cnt;
  exp_t       e;

  // Monitor: compare each finished lamp phase against the scoreboard.
  always @(negedge clk) begin
    cur_l = {main_lights, side_lights, walk};
    if (reset) begin
      prev_l  = cur_l;
      seg_cnt = 0;
      ack_cnt = 0;
    end else begin
      seg_cnt++;
      if (ped_ack) ack_cnt++;
      if (cur_l[0] && !prev_l[0]) begin
        applied++;
        if (ped_ack !== 1'b1) begin
          errors++;
          $display("FAIL walk_entry_ack: ped_ack=%b required 1", ped_ack);
        end
      end else if (ped_ack) begin
        errors++;
        $display("FAIL stray_ack: ped_ack=1 without walk entry, lamps=%b", cur_l);
      end
      if (((main_lights[1:0] != 2'b00) && (side_lights[1:0] != 2'b00)) ||
          (walk && ((main_lights != 3'b100) || (side_lights != 3'b100)))) begin
        errors++;
        $display("FAIL invariant: lamps=%b", cur_l);
      end
      if (cur_l != prev_l) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: %b -> %b, none expected", prev_l, cur_l);
        end else begin
          e = exp_q.pop_front();
          applied++;
          if (e.lamps != prev_l) begin
            errors++;
            $display("FAIL phase_lamps: got %b required %b", prev_l, e.lamps);
          end
          if (e.dwell != 0) begin
            applied++;
            if (seg_cnt != e.dwell) begin
              errors++;
              $display("FAIL phase_dwell: lamps %b lasted %0d cycles required %0d",
                       prev_l, seg_cnt, e.dwell);
            end
          end
        end
        prev_l  = cur_l;
        seg_cnt = 0;
      end
    end
  end

  task automatic push(input logic [6:0] lamps, input int dwell);
    exp_t x;
    x.lamps = lamps;
    x.dwell = dwell;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_lamps(input logic [6:0] exp, input string tag);
    applied++;
    if ({main_lights, side_lights, walk} !== exp) begin
      errors++;
      $display("FAIL %s: lamps got %b required %b", tag, {main_lights, side_lights, walk}, exp);
    end
  endtask

  task automatic check_acks(input int exp, input string tag);
    applied++;
    if (ack_cnt != exp) begin
      errors++;
      $display("FAIL %s: ped_ack pulses got %0d required %0d", tag, ack_cnt, exp);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    applied++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d phases still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge; released
  // 1 time unit after a rising edge (call that edge cycle 0).
  task automatic do_reset();
    exp_q.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_lamps(L_MG, "async_reset_lamps");
    applied++;
    if (ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ack: ped_ack=%b required 0", ped_ack);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Reset and idle
    do_reset();
    cyc(200);
    check_lamps(L_MG, "idle_lamps");
    check_acks(0, "idle_acks");

    // Pedestrian: press at cycle 20, held low (no second edge)
    ped_btn_n = 1'b1; car_sensor = 1'b0;
    do_reset();
    push(L_MG, 0); push(L_MY, 8); push(L_AR, 4); push(L_WK, 20); push(L_AR, 4);
    cyc(20); ped_btn_n = 1'b0;
    drain(200);
    cyc(40);
    check_lamps(L_MG, "ped_final");
    check_acks(1, "ped_acks");

    // Car present from cycle 0, leaves during side green
    ped_btn_n = 1'b1; car_sensor = 1'b1;
    do_reset();
    push(L_MG, 0); push(L_MY, 8); push(L_AR, 4); push(L_SG, 16); push(L_SY, 8); push(L_AR, 4);
    cyc(30); car_sensor = 1'b0;
    drain(200);
    cyc(40);
    check_lamps(L_MG, "car_final");
    check_acks(0, "car_acks");

    // Button and car together: walk first, then full min green, then side
    ped_btn_n = 1'b1; car_sensor = 1'b0;
    do_reset();
    push(L_MG, 0); push(L_MY, 8); push(L_AR, 4); push(L_WK, 20); push(L_AR, 4);
    push(L_MG, 12); push(L_MY, 8); push(L_AR, 4); push(L_SG, 16); push(L_SY, 8); push(L_AR, 4);
    cyc(20); ped_btn_n = 1'b0; car_sensor = 1'b1;
    cyc(70); car_sensor = 1'b0;
    drain(300);
    cyc(40);
    check_lamps(L_MG, "simul_final");
    check_acks(1, "simul_acks");

    // Re-press landing on the WALK entry edge (cycle 36), then held low
    ped_btn_n = 1'b1; car_sensor = 1'b0;
    do_reset();
    push(L_MG, 0); push(L_MY, 8); push(L_AR, 4); push(L_WK, 20); push(L_AR, 4);
    push(L_MG, 12); push(L_MY, 8); push(L_AR, 4); push(L_WK, 20); push(L_AR, 4);
    cyc(20); ped_btn_n = 1'b0;
    cyc(5);  ped_btn_n = 1'b1;
    cyc(10); ped_btn_n = 1'b0;
    drain(300);
    cyc(60);
    check_lamps(L_MG, "repress_final");
    check_acks(2, "repress_acks");

`ifdef TLC_NIGHT_FLASH_EN
    // Night flashing; presses during NIGHT are discarded
    ped_btn_n = 1'b1; car_sensor = 1'b0; night_mode = 1'b1;
    do_reset();
    push(L_MG, 0); push(L_NL, 8); push(L_NO, 8); push(L_NL, 8); push(L_NO, 4); push(L_AR, 4);
    cyc(10); ped_btn_n = 1'b0;
    cyc(5);  ped_btn_n = 1'b1;
    cyc(7);  ped_btn_n = 1'b0;
    cyc(8);  night_mode = 1'b0;
    drain(200);
    cyc(40);
    check_lamps(L_MG, "night_final");
    check_acks(0, "night_acks");
`endif

    // Asynchronous reset taken while side green is showing
    ped_btn_n = 1'b1; car_sensor = 1'b1;
    do_reset();
    push(L_MG, 0); push(L_MY, 8); push(L_AR, 4);
    cyc(30);
    check_lamps(L_SG, "pre_reset_side_green");
    car_sensor = 1'b0;
    do_reset();
    cyc(20);
    check_lamps(L_MG, "post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
